// File: rtl/counters_pkg.sv
// Shared constants and helpers for the counters family.
package counters_pkg;

    localparam bit CNT_WRAP = 1'b0;
    localparam bit CNT_SAT  = 1'b1;

    // Out-of-range load values are pinned to the top of the count range.
    function automatic logic [31:0] clamp_load(input logic [31:0] d, input logic [31:0] max_val);
        return (d > max_val) ? max_val : d;
    endfunction

endpackage

// File: rtl/counter_updown_mod_if.sv
// Control/status bundle of the up/down modulo counter.
interface counter_updown_mod_if #(
    parameter int WIDTH = 4
);
    logic             CE;
    logic             UP;
    logic             SLOAD;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q;
    logic             TC;
    logic             OVF;

    modport master (output CE, UP, SLOAD, D, input Q, TC, OVF);
    modport slave  (input CE, UP, SLOAD, D, output Q, TC, OVF);
endinterface

// File: rtl/counter_next.sv
// Combinational next-count for one enabled step, plus end-of-range detection.
module counter_next
    import counters_pkg::*;
#(
    parameter int          WIDTH    = 4,
    parameter int unsigned MAX_VAL  = (1 << WIDTH) - 1,
    parameter bit          SATURATE = CNT_WRAP
) (
    input  logic [WIDTH-1:0] q,
    input  logic             up,
    output logic [WIDTH-1:0] nxt,
    output logic             end_event
);

    localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MAX_VAL);

    logic [WIDTH:0] q_ext;
    logic [WIDTH:0] step;

    // The extra bit on the down path is the borrow, i.e. q was zero.
    always_comb begin
        q_ext     = {1'b0, q};
        step      = up ? (q_ext + (WIDTH+1)'(1)) : (q_ext - (WIDTH+1)'(1));
        nxt       = step[WIDTH-1:0];
        end_event = 1'b0;
        if (up && (q_ext == MAX_EXT)) begin
            end_event = 1'b1;
            nxt       = SATURATE ? q : '0;
        end else if (!up && step[WIDTH]) begin
            end_event = 1'b1;
            nxt       = SATURATE ? q : MAX_Q;
        end
    end

endmodule

// File: rtl/counter_updown_mod.sv
// Parametrised up/down modulo counter with load, wrap/saturate mode, TC and sticky OVF.
module counter_updown_mod
    import counters_pkg::*;
#(
    parameter int          WIDTH    = 4,
    parameter int unsigned MAX_VAL  = (1 << WIDTH) - 1,
    parameter bit          SATURATE = CNT_WRAP,
    parameter int unsigned INIT     = 0
) (
    input logic               C,
    input logic               CLR,
    counter_updown_mod_if.slave bus
);

    if (WIDTH < 1 || WIDTH > 31) begin : g_bad_width
        $error("counter_updown_mod: WIDTH must be in 1..31");
    end
    if (MAX_VAL == 0 || MAX_VAL > ((1 << WIDTH) - 1)) begin : g_bad_max
        $error("counter_updown_mod: MAX_VAL must satisfy 0 < MAX_VAL <= 2**WIDTH-1");
    end
    if (INIT > MAX_VAL) begin : g_bad_init
        $error("counter_updown_mod: INIT must not exceed MAX_VAL");
    end

    localparam logic [WIDTH-1:0] INIT_Q = WIDTH'(INIT);

    logic [WIDTH-1:0] q;
    logic             ovf;
    logic [WIDTH-1:0] nxt;
    logic             end_event;
    logic [WIDTH-1:0] load_val;

    counter_next #(
        .WIDTH    (WIDTH),
        .MAX_VAL  (MAX_VAL),
        .SATURATE (SATURATE)
    ) u_next (
        .q         (q),
        .up        (bus.UP),
        .nxt       (nxt),
        .end_event (end_event)
    );

    assign load_val = WIDTH'(clamp_load(32'(bus.D), 32'(MAX_VAL)));

    // Priority: CLR (async) > SLOAD > CE; OVF only ever set by a counted end event.
    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            q   <= INIT_Q;
            ovf <= 1'b0;
        end else if (bus.SLOAD) begin
            q   <= load_val;
            ovf <= 1'b0;
        end else if (bus.CE) begin
            q <= nxt;
            if (end_event) begin
                ovf <= 1'b1;
            end
        end
    end

    assign bus.Q   = q;
    assign bus.OVF = ovf;
    assign bus.TC  = bus.CE & end_event;

endmodule

// File: tb/tb_counter_updown_mod.sv
// Directed bench for counter_updown_mod: wrap, saturate, load clamp, async reset, direction, cascade.
module tb_counter_updown_mod;
    import counters_pkg::*;

    logic clk = 1'b0;
    logic clr;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    counter_updown_mod_if #(.WIDTH(4)) wrap_if ();
    counter_updown_mod_if #(.WIDTH(4)) sat_if ();
    counter_updown_mod_if #(.WIDTH(4)) init_if ();
    counter_updown_mod_if #(.WIDTH(4)) lo_if ();
    counter_updown_mod_if #(.WIDTH(4)) hi_if ();

    assign hi_if.CE = lo_if.TC;
    assign hi_if.UP = lo_if.UP;

    counter_updown_mod #(.WIDTH(4), .MAX_VAL(9), .SATURATE(CNT_WRAP), .INIT(0))
        u_wrap (.C(clk), .CLR(clr), .bus(wrap_if));
    counter_updown_mod #(.WIDTH(4), .MAX_VAL(9), .SATURATE(CNT_SAT), .INIT(0))
        u_sat (.C(clk), .CLR(clr), .bus(sat_if));
    counter_updown_mod #(.WIDTH(4), .MAX_VAL(9), .SATURATE(CNT_WRAP), .INIT(5))
        u_init (.C(clk), .CLR(clr), .bus(init_if));
    counter_updown_mod #(.WIDTH(4), .MAX_VAL(9), .SATURATE(CNT_WRAP), .INIT(0))
        u_lo (.C(clk), .CLR(clr), .bus(lo_if));
    counter_updown_mod #(.WIDTH(4), .MAX_VAL(9), .SATURATE(CNT_WRAP), .INIT(0))
        u_hi (.C(clk), .CLR(clr), .bus(hi_if));

    task automatic edge_wait();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clr = 1'b1;
        wrap_if.CE = 0; wrap_if.UP = 0; wrap_if.SLOAD = 0; wrap_if.D = '0;
        sat_if.CE  = 0; sat_if.UP  = 0; sat_if.SLOAD  = 0; sat_if.D  = '0;
        init_if.CE = 0; init_if.UP = 0; init_if.SLOAD = 0; init_if.D = '0;
        lo_if.CE   = 0; lo_if.UP   = 0; lo_if.SLOAD   = 0; lo_if.D   = '0;
        hi_if.SLOAD = 0; hi_if.D = '0;
        #2;
        n_total++;
        if (wrap_if.Q !== 4'd0 || wrap_if.OVF !== 1'b0 || wrap_if.TC !== 1'b0)
            $display("FAIL reset_wrap: Q=%0d OVF=%b TC=%b, want Q=0 OVF=0 TC=0", wrap_if.Q, wrap_if.OVF, wrap_if.TC);
        else n_pass++;
        n_total++;
        if (init_if.Q !== 4'd5 || init_if.OVF !== 1'b0)
            $display("FAIL reset_init: Q=%0d OVF=%b, want Q=5 OVF=0", init_if.Q, init_if.OVF);
        else n_pass++;
        wrap_if.CE = 1; wrap_if.UP = 0;
        #1;
        n_total++;
        if (wrap_if.TC !== 1'b1)
            $display("FAIL reset_tc_down: TC=%b, want 1", wrap_if.TC);
        else n_pass++;
        edge_wait();
        n_total++;
        if (wrap_if.Q !== 4'd0 || wrap_if.OVF !== 1'b0)
            $display("FAIL reset_hold: Q=%0d OVF=%b, want Q=0 OVF=0", wrap_if.Q, wrap_if.OVF);
        else n_pass++;
        clr = 1'b0;
        wrap_if.CE = 0;
    endtask

    task automatic test_wrap_up();
        logic [3:0] exp_q;
        wrap_if.CE = 1; wrap_if.UP = 1;
        #1;
        n_total++;
        if (wrap_if.TC !== 1'b0)
            $display("FAIL wrap_tc_start: TC=%b, want 0", wrap_if.TC);
        else n_pass++;
        for (int i = 1; i <= 12; i++) begin
            edge_wait();
            exp_q = 4'(i % 10);
            n_total++;
            if (wrap_if.Q !== exp_q || wrap_if.TC !== (exp_q == 4'd9) || wrap_if.OVF !== (i >= 10))
                $display("FAIL wrap_up[%0d]: Q=%0d TC=%b OVF=%b, want Q=%0d TC=%b OVF=%b",
                         i, wrap_if.Q, wrap_if.TC, wrap_if.OVF, exp_q, (exp_q == 4'd9), (i >= 10));
            else n_pass++;
        end
        wrap_if.CE = 0;
    endtask

    task automatic test_sat_down();
        logic [3:0] exp_q [5] = '{4'd1, 4'd0, 4'd0, 4'd0, 4'd0};
        sat_if.SLOAD = 1; sat_if.D = 4'd2;
        edge_wait();
        n_total++;
        if (sat_if.Q !== 4'd2 || sat_if.OVF !== 1'b0)
            $display("FAIL sat_load: Q=%0d OVF=%b, want Q=2 OVF=0", sat_if.Q, sat_if.OVF);
        else n_pass++;
        sat_if.SLOAD = 0; sat_if.CE = 1; sat_if.UP = 0;
        for (int i = 0; i < 5; i++) begin
            edge_wait();
            n_total++;
            if (sat_if.Q !== exp_q[i] || sat_if.OVF !== (i >= 2) || sat_if.TC !== (exp_q[i] == 4'd0))
                $display("FAIL sat_down[%0d]: Q=%0d OVF=%b TC=%b, want Q=%0d OVF=%b TC=%b",
                         i + 1, sat_if.Q, sat_if.OVF, sat_if.TC, exp_q[i], (i >= 2), (exp_q[i] == 4'd0));
            else n_pass++;
        end
        sat_if.CE = 0;
    endtask

    task automatic test_load_clamp();
        wrap_if.SLOAD = 1; wrap_if.D = 4'd14;
        edge_wait();
        n_total++;
        if (wrap_if.Q !== 4'd9 || wrap_if.OVF !== 1'b0)
            $display("FAIL load_clamp: Q=%0d OVF=%b, want Q=9 OVF=0", wrap_if.Q, wrap_if.OVF);
        else n_pass++;
        wrap_if.CE = 1; wrap_if.UP = 1; wrap_if.D = 4'd3;
        edge_wait();
        n_total++;
        if (wrap_if.Q !== 4'd3 || wrap_if.OVF !== 1'b0)
            $display("FAIL load_beats_ce: Q=%0d OVF=%b, want Q=3 OVF=0", wrap_if.Q, wrap_if.OVF);
        else n_pass++;
        wrap_if.SLOAD = 0; wrap_if.CE = 0;
    endtask

    task automatic test_direction_hold();
        logic       ups   [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [3:0] exp_q [6] = '{4'd5, 4'd4, 4'd3, 4'd4, 4'd4, 4'd4};
        wrap_if.SLOAD = 1; wrap_if.D = 4'd4;
        edge_wait();
        wrap_if.SLOAD = 0;
        for (int i = 0; i < 6; i++) begin
            wrap_if.CE = (i < 4);
            wrap_if.UP = (i < 4) ? ups[i] : 1'b1;
            edge_wait();
            n_total++;
            if (wrap_if.Q !== exp_q[i])
                $display("FAIL dir_hold[%0d]: Q=%0d, want %0d", i, wrap_if.Q, exp_q[i]);
            else n_pass++;
        end
        wrap_if.CE = 0;
    endtask

    task automatic test_async_reset();
        init_if.SLOAD = 1; init_if.D = 4'd9;
        edge_wait();
        init_if.SLOAD = 0; init_if.CE = 1; init_if.UP = 1;
        edge_wait();
        n_total++;
        if (init_if.Q !== 4'd0 || init_if.OVF !== 1'b1)
            $display("FAIL init_wrap: Q=%0d OVF=%b, want Q=0 OVF=1", init_if.Q, init_if.OVF);
        else n_pass++;
        repeat (7) edge_wait();
        n_total++;
        if (init_if.Q !== 4'd7)
            $display("FAIL init_count: Q=%0d, want 7", init_if.Q);
        else n_pass++;
        #2;
        clr = 1'b1;
        init_if.SLOAD = 1; init_if.D = 4'd2;
        #1;
        n_total++;
        if (init_if.Q !== 4'd5 || init_if.OVF !== 1'b0)
            $display("FAIL async_clr: Q=%0d OVF=%b, want Q=5 OVF=0", init_if.Q, init_if.OVF);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            edge_wait();
            n_total++;
            if (init_if.Q !== 4'd5 || init_if.OVF !== 1'b0)
                $display("FAIL clr_hold[%0d]: Q=%0d OVF=%b, want Q=5 OVF=0", i, init_if.Q, init_if.OVF);
            else n_pass++;
        end
        clr = 1'b0;
        init_if.SLOAD = 0;
        edge_wait();
        n_total++;
        if (init_if.Q !== 4'd6)
            $display("FAIL post_clr: Q=%0d, want 6", init_if.Q);
        else n_pass++;
        init_if.CE = 0;
    endtask

    task automatic test_cascade();
        lo_if.CE = 1; lo_if.UP = 1;
        for (int i = 1; i <= 100; i++) begin
            edge_wait();
            if (i == 37) begin
                n_total++;
                if (lo_if.Q !== 4'd7 || hi_if.Q !== 4'd3 || hi_if.OVF !== 1'b0)
                    $display("FAIL cascade_37: hi=%0d lo=%0d hiOVF=%b, want hi=3 lo=7 hiOVF=0",
                             hi_if.Q, lo_if.Q, hi_if.OVF);
                else n_pass++;
            end
            if (i == 99) begin
                n_total++;
                if (lo_if.Q !== 4'd9 || hi_if.Q !== 4'd9 || hi_if.TC !== 1'b1)
                    $display("FAIL cascade_99: hi=%0d lo=%0d hiTC=%b, want hi=9 lo=9 hiTC=1",
                             hi_if.Q, lo_if.Q, hi_if.TC);
                else n_pass++;
            end
        end
        n_total++;
        if (lo_if.Q !== 4'd0 || hi_if.Q !== 4'd0 || lo_if.OVF !== 1'b1 || hi_if.OVF !== 1'b1)
            $display("FAIL cascade_100: hi=%0d lo=%0d hiOVF=%b loOVF=%b, want 0 0 1 1",
                     hi_if.Q, lo_if.Q, hi_if.OVF, lo_if.OVF);
        else n_pass++;
        lo_if.CE = 0;
    endtask

    initial begin
        test_reset();
        test_wrap_up();
        test_sat_down();
        test_load_clamp();
        test_direction_hold();
        test_async_reset();
        test_cascade();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run still active at %0t, want finished", $time);
        $fatal(1);
    end

endmodule
